// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter in front of the flash ROM read controller.
// One load pulse per transaction, ready-or-watchdog completion, one-cycle ack.
module rom_arbiter #(
  parameter int WIDTH    = 16,
  parameter int ROM_ADDR = 23,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0,
  input  logic [ROM_ADDR-1:0] addr0,
  output logic                ack0,
  input  logic                req1,
  input  logic [ROM_ADDR-1:0] addr1,
  output logic                ack1,
  output logic [WIDTH-1:0]    rdata,
  output logic                err,
  output logic                busy,
  output logic [ROM_ADDR-1:0] rom_addr,
  output logic                rom_load,
  input  logic [WIDTH-1:0]    rom_data,
  input  logic                rom_ready
);

  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic [ROM_ADDR-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]    rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [WDW-1:0]      wdog_q, wdog_d;

  logic                eff0, eff1, pick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    wdog_d  = wdog_q;
    // The ack cycle is spent in IDLE while the acked port still holds req;
    // that req belongs to the finished transaction, so it is masked here.
    eff0    = req0 & ~ack0_q;
    eff1    = req1 & ~ack1_q;
    pick    = 1'b0;

    case (state_q)
      IDLE: begin
        if (eff0 && eff1) pick = ~last_q;
        else              pick = eff1;
        if (eff0 || eff1) begin
          addr_d  = pick ? addr1 : addr0;
          gnt_d   = pick;
          last_d  = pick;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (rom_ready) begin
          rdata_d = rom_data;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (wdog_q == WD_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      DONE: begin
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata    = rdata_q;
  assign err      = err_q;
  assign rom_addr = addr_q;
  assign rom_load = (state_q == ISSUE);
  assign busy     = (state_q == ISSUE) || (state_q == WAIT);

endmodule
